// File: rtl/clk_div_ctrl.sv
// rtl/clk_div_ctrl.sv - glitch-free programmable mclk divider with handshaked ratio change
// Optional lock detector is compiled in with macro CLK_DIV_LOCK_EN.
module clk_div_ctrl #(
  parameter int DIV_W   = 4,
  parameter int DIV_RST = 2
) (
  input  logic             mclk,
  input  logic             rst,
  input  logic             en,
  input  logic             div_req,
  input  logic [DIV_W-1:0] div_val,
  output logic             div_ack,
  output logic             err,
  output logic             busy,
  output logic             bclk,
  output logic             lock
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PEND = 2'd2, STOP = 2'd3} state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] n_q, n_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] pend_n_q, pend_n_d;
  logic             ack_q, ack_d;
  logic             err_q, err_d;
  logic             busy_q, busy_d;
  logic             bclk_q, bclk_d;
  logic             wrap;
  logic             legal;
  logic [DIV_W-1:0] cnt_inc;
  logic [DIV_W:0]   half;

  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    cnt_d    = cnt_q;
    pend_n_d = pend_n_q;
    ack_d    = 1'b0;
    err_d    = 1'b0;
    legal    = (div_val >= DIV_W'(2));
    wrap     = (cnt_q == n_q - DIV_W'(1));
    cnt_inc  = wrap ? '0 : cnt_q + DIV_W'(1);

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (div_req) begin
          if (legal) begin
            n_d   = div_val;
            ack_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
        if (en) state_d = RUN;
      end
      RUN: begin
        cnt_d = cnt_inc;
        // A legal request wins over en=0; PEND decides stop-or-run at the boundary.
        if (div_req && legal) begin
          pend_n_d = div_val;
          state_d  = PEND;
        end else begin
          if (div_req) err_d = 1'b1;
          if (!en) state_d = STOP;
        end
      end
      PEND: begin
        cnt_d = cnt_inc;
        if (wrap) begin
          n_d     = pend_n_q;
          ack_d   = 1'b1;
          state_d = en ? RUN : IDLE;
        end
      end
      STOP: begin
        cnt_d = cnt_inc;
        if (en) state_d = RUN;
        else if (wrap) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    half   = ({1'b0, n_d} + (DIV_W+1)'(1)) >> 1;
    bclk_d = (state_d != IDLE) && ({1'b0, cnt_d} < half);
    busy_d = (state_d == PEND) || (state_d == STOP);
  end

  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      n_q      <= DIV_W'(DIV_RST);
      cnt_q    <= '0;
      pend_n_q <= '0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      bclk_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      n_q      <= n_d;
      cnt_q    <= cnt_d;
      pend_n_q <= pend_n_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
      bclk_q   <= bclk_d;
    end
  end

  assign div_ack = ack_q;
  assign err     = err_q;
  assign busy    = busy_q;
  assign bclk    = bclk_q;

`ifdef CLK_DIV_LOCK_EN
  // Counts completed RUN periods since the last (re)start or ratio load, saturating at 2.
  logic [1:0] lock_cnt_q, lock_cnt_d;
  logic       lock_q, lock_d;

  always_comb begin
    lock_cnt_d = lock_cnt_q;
    if (!((state_d == RUN) || (state_d == PEND)) || ack_d) begin
      lock_cnt_d = 2'd0;
    end else if ((state_q == RUN) && wrap && (lock_cnt_q != 2'd2)) begin
      lock_cnt_d = lock_cnt_q + 2'd1;
    end
    lock_d = (lock_cnt_d == 2'd2);
  end

  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      lock_cnt_q <= 2'd0;
      lock_q     <= 1'b0;
    end else begin
      lock_cnt_q <= lock_cnt_d;
      lock_q     <= lock_d;
    end
  end

  assign lock = lock_q;
`else
  assign lock = 1'b0;
`endif

endmodule

// File: tb/tb_clk_div_ctrl.sv
// tb/tb_clk_div_ctrl.sv - directed vector table plus randomized run against a behavioural model
module tb_clk_div_ctrl;
  localparam int DIV_W   = 4;
  localparam int DIV_RST = 2;
`ifdef CLK_DIV_LOCK_EN
  localparam bit LOCK_ON = 1'b1;
`else
  localparam bit LOCK_ON = 1'b0;
`endif

  logic             mclk = 1'b0;
  logic             rst, en, div_req;
  logic [DIV_W-1:0] div_val;
  logic             div_ack, err, busy, bclk, lock;

  clk_div_ctrl #(.DIV_W(DIV_W), .DIV_RST(DIV_RST)) dut (
    .mclk(mclk), .rst(rst), .en(en), .div_req(div_req), .div_val(div_val),
    .div_ack(div_ack), .err(err), .busy(busy), .bclk(bclk), .lock(lock)
  );

  always #5 mclk = ~mclk;

  int checks = 0;
  int errors = 0;

  // Behavioural model: clock on/off, pending-change and stop-request flags, phase within period.
  bit m_on, m_pending, m_stopping;
  int m_n, m_pend_n, m_phase, m_good;
  bit m_bclk, m_ack, m_err, m_busy, m_lock;

  typedef struct {
    logic en; logic req; logic [3:0] val;
    logic b; logic a; logic e; logic bz;
  } vec_t;
  vec_t vq[$];

  task automatic model_reset();
    m_on = 0; m_pending = 0; m_stopping = 0;
    m_n = DIV_RST; m_pend_n = 0; m_phase = 0; m_good = 0;
    m_bclk = 0; m_ack = 0; m_err = 0; m_busy = 0; m_lock = 0;
  endtask

  task automatic model_step(input logic e, input logic r, input logic [3:0] v);
    bit wrap, legal;
    legal = (v >= 2);
    m_ack = 0;
    m_err = 0;
    if (!m_on) begin
      if (r && legal) begin m_n = v; m_ack = 1; end
      else if (r) m_err = 1;
      if (e) begin m_on = 1; m_phase = 0; m_good = 0; end
    end else begin
      wrap    = (m_phase == m_n - 1);
      m_phase = wrap ? 0 : m_phase + 1;
      if (m_pending) begin
        if (wrap) begin
          m_n = m_pend_n; m_ack = 1; m_pending = 0; m_good = 0; m_on = e;
        end
      end else if (m_stopping) begin
        if (e) m_stopping = 0;
        else if (wrap) begin m_stopping = 0; m_on = 0; end
      end else begin
        if (wrap && m_good < 2) m_good++;
        if (r && legal) begin m_pending = 1; m_pend_n = v; end
        else begin
          if (r) m_err = 1;
          if (!e) begin m_stopping = 1; m_good = 0; end
        end
      end
    end
    m_bclk = m_on && (m_phase < (m_n + 1) / 2);
    m_busy = m_on && (m_pending || m_stopping);
    m_lock = LOCK_ON && m_on && !m_stopping && (m_good >= 2);
  endtask

  task automatic check_out(input string name);
    logic [4:0] got, exp;
    got = {bclk, div_ack, err, busy, lock};
    exp = {m_bclk, m_ack, m_err, m_busy, m_lock};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0t: got {bclk,ack,err,busy,lock}=%05b expected %05b", name, $time, got, exp);
    end
  endtask

  task automatic cycle(input logic e, input logic r, input logic [3:0] v, input string name);
    en = e; div_req = r; div_val = v;
    model_step(e, r, v);
    @(posedge mclk);
    @(negedge mclk);
    check_out(name);
  endtask

  // Called at a negedge: assert reset between edges, hold it across one edge, release.
  task automatic async_reset(input string name);
    #2 rst = 1'b1;
    #1 model_reset();
    check_out({name, "_now"});
    @(negedge mclk);
    check_out({name, "_hold"});
    rst = 1'b0;
  endtask

  task automatic add(input logic e, input logic r, input logic [3:0] v,
                     input logic b, input logic a, input logic er, input logic bz);
    vec_t t;
    t.en = e; t.req = r; t.val = v; t.b = b; t.a = a; t.e = er; t.bz = bz;
    vq.push_back(t);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; div_req = 1'b0; div_val = '0;
    model_reset();
    #1 check_out("reset_state");
    @(negedge mclk);
    rst = 1'b0;

    //  en req val   bclk ack err busy
    add(1, 0, 0,    1, 0, 0, 0);  // start, N=2
    add(1, 0, 0,    0, 0, 0, 0);
    add(1, 0, 0,    1, 0, 0, 0);
    add(1, 1, 1,    0, 0, 1, 0);  // illegal ratio
    add(1, 0, 0,    1, 0, 0, 0);
    add(1, 1, 5,    0, 0, 0, 1);  // change to 5 mid-period
    add(1, 0, 0,    1, 1, 0, 0);  // boundary: load, ack
    add(1, 0, 0,    1, 0, 0, 0);
    add(1, 0, 0,    1, 0, 0, 0);
    add(1, 0, 0,    0, 0, 0, 0);
    add(1, 0, 0,    0, 0, 0, 0);
    add(1, 0, 0,    1, 0, 0, 0);
    add(1, 1, 3,    1, 0, 0, 1);  // change to 3
    add(1, 1, 4,    1, 0, 0, 1);  // ignored while pending
    add(1, 0, 0,    0, 0, 0, 1);
    add(1, 0, 0,    0, 0, 0, 1);
    add(1, 0, 0,    1, 1, 0, 0);
    add(1, 0, 0,    1, 0, 0, 0);
    add(1, 0, 0,    0, 0, 0, 0);
    add(1, 0, 0,    1, 0, 0, 0);
    add(0, 0, 0,    1, 0, 0, 1);  // stop request
    add(0, 0, 0,    0, 0, 0, 1);
    add(0, 0, 0,    0, 0, 0, 0);  // idle at boundary
    add(0, 0, 0,    0, 0, 0, 0);
    add(1, 0, 0,    1, 0, 0, 0);
    add(0, 0, 0,    1, 0, 0, 1);
    add(1, 0, 0,    0, 0, 0, 0);  // re-enable before boundary
    add(1, 0, 0,    1, 0, 0, 0);
    add(0, 1, 2,    1, 0, 0, 1);  // change and stop together
    add(0, 0, 0,    0, 0, 0, 1);
    add(0, 0, 0,    0, 1, 0, 0);
    add(0, 0, 0,    0, 0, 0, 0);
    add(0, 1, 4,    0, 1, 0, 0);  // load in idle
    add(1, 0, 0,    1, 0, 0, 0);  // N=4
    add(1, 0, 0,    1, 0, 0, 0);
    add(0, 0, 0,    0, 0, 0, 1);  // stop during high phase
    add(0, 0, 0,    0, 0, 0, 1);
    add(0, 0, 0,    0, 0, 0, 0);
    add(1, 0, 0,    1, 0, 0, 0);

    for (int i = 0; i < vq.size(); i++) begin
      cycle(vq[i].en, vq[i].req, vq[i].val, $sformatf("vec%0d_model", i));
      checks++;
      if ({bclk, div_ack, err, busy} !== {vq[i].b, vq[i].a, vq[i].e, vq[i].bz}) begin
        errors++;
        $display("FAIL vec%0d: got {bclk,ack,err,busy}=%04b expected %04b", i,
                 {bclk, div_ack, err, busy}, {vq[i].b, vq[i].a, vq[i].e, vq[i].bz});
      end
    end

    // Reset while a ratio change is pending: no ack afterwards, ratio back to DIV_RST.
    cycle(1, 1, 5, "pend_before_rst");
    async_reset("rst_pend");
    for (int i = 0; i < 6; i++) cycle(1, 0, 0, $sformatf("post_rst%0d", i));

    for (int i = 0; i < 3000; i++) begin
      logic e, r;
      logic [3:0] v;
      e = ($urandom_range(0, 7) != 0);
      r = ($urandom_range(0, 5) == 0);
      v = 4'($urandom_range(0, 15));
      cycle(e, r, v, $sformatf("rand%0d", i));
      if ($urandom_range(0, 299) == 0) async_reset($sformatf("rand_rst%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
